updown_counter_p: RTL and testbench
===================================

UPDOWN_COUNTER_P -- requirements
Module: updown_counter_p

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MAX_VAL, default 2**WIDTH-1, terminal count (legal range 1..2**WIDTH-1).
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = wrap at the bounds, 1 = hold at the bounds.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port areset, input, 1, reset, asynchronous and active-high.
REQ-006 The block SHALL have port enable, input, 1, count-enable qualifier.
REQ-007 The block SHALL have port up, input, 1, direction: 1 = increment, 0 = decrement.
REQ-008 The block SHALL have port load, input, 1, synchronous parallel load strobe.
REQ-009 The block SHALL have port load_val, input, WIDTH, value to load.
REQ-010 The block SHALL have port clr_flags, input, 1, synchronous clear of the sticky flags.
REQ-011 The block SHALL have port q, output, WIDTH, the registered count.
REQ-012 The block SHALL have port at_max, output, 1, combinational (q == MAX_VAL).
REQ-013 The block SHALL have port at_min, output, 1, combinational (q == 0).
REQ-014 The block SHALL have port wrap, output, 1, registered one-cycle pulse marking a boundary crossing.
REQ-015 The block SHALL have port ovf_sticky, output, 1, registered sticky overflow flag.
REQ-016 The block SHALL have port udf_sticky, output, 1, registered sticky underflow flag.

Function
REQ-017 The count SHALL update with priority load > enable > hold on each rising clk edge.
REQ-018 When load=1, q SHALL take min(load_val, MAX_VAL) regardless of enable and up.
REQ-019 When load=1, the load SHALL NOT generate wrap, ovf or udf events.
REQ-020 When load=0 and enable=1 and up=1 with q<MAX_VAL, q SHALL become q+1.
REQ-021 When load=0 and enable=1 and up=0 with q>0, q SHALL become q-1.
REQ-022 Overflow event: up=1 with q==MAX_VAL; if SATURATE=0, q SHALL become 0, otherwise q SHALL hold at MAX_VAL.
REQ-023 Underflow event: up=0 with q==0; if SATURATE=0, q SHALL become MAX_VAL, otherwise q SHALL hold at 0.
REQ-024 When load=0 and enable=0, q SHALL hold and no event SHALL occur; in this case up SHALL be ignored.
REQ-025 wrap SHALL be high for exactly the cycle following an overflow or underflow event with SATURATE=0, and low otherwise.
REQ-026 wrap SHALL never assert when SATURATE=1.
REQ-027 An overflow event SHALL set ovf_sticky, and an underflow event SHALL set udf_sticky, in both modes, visible the cycle after the event.
REQ-028 clr_flags=1 SHALL clear both sticky flags on the next edge; if a set event occurs in the same cycle, set SHALL win.
REQ-029 Counting arithmetic SHALL be modulo MAX_VAL+1; intermediate results SHALL never exceed WIDTH bits and no out-of-range q SHALL ever be produced.
REQ-030 A change of up while enable=1 SHALL take effect on the same edge, with no dead cycle.

Reset
REQ-031 While areset=1, q, wrap, ovf_sticky and udf_sticky SHALL be 0 immediately, independent of clk; therefore at_min=1, and at_max=0.
REQ-032 Assertion of areset in the middle of counting or loading SHALL abort the operation; the first edge after deassertion SHALL apply the normal rules from q=0.

Verification
REQ-033 WIDTH=4, MAX_VAL=9, SATURATE=0: reset, then enable=1, up=1 for 11 cycles -> q runs 1..9,0,1; wrap high one cycle after the 9->0 edge; ovf_sticky=1.
REQ-034 Same configuration: from q=0, enable=1, up=0 -> q=9; wrap pulses once; udf_sticky=1; then clr_flags=1 for one cycle -> both sticky flags return to 0.
REQ-035 WIDTH=4, default MAX_VAL=15, SATURATE=1: count up past 15 -> q holds at 15, at_max=1, wrap stays 0, ovf_sticky=1; count down past 0 -> q holds at 0, udf_sticky=1.
REQ-036 load=1, load_val=12, MAX_VAL=9 with enable=1 -> q=9 and no flag set; load=1 with enable=0 and load_val=3 -> q=3.
REQ-037 Toggle enable every cycle and up every 3 cycles with random stimulus -> q matches the reference model each cycle; q holds on every enable=0 cycle.
REQ-038 Assert areset asynchronously mid-count at q=7 between edges -> q=0 and flags cleared before the next edge; after release, counting resumes 1,2,... .

Source files
------------

// File: rtl/updown_counter_p.sv
// Up/down counter with programmable terminal count, wrap or saturate at the bounds,
// a one-cycle wrap pulse and sticky overflow/underflow flags.
module updown_counter_p #(
    parameter int                 WIDTH    = 4,
    parameter logic [WIDTH-1:0]   MAX_VAL  = {WIDTH{1'b1}},
    parameter bit                 SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] q,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap,
    output logic             ovf_sticky,
    output logic             udf_sticky
);

    logic [WIDTH-1:0] next_q;
    logic             ovf_ev;
    logic             udf_ev;

    assign at_max = (q == MAX_VAL);
    assign at_min = (q == '0);

    // Loads are clamped to the terminal count so q can never leave 0..MAX_VAL.
    always_comb begin
        next_q = q;
        ovf_ev = 1'b0;
        udf_ev = 1'b0;
        if (load) begin
            next_q = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (enable) begin
            if (up) begin
                if (q == MAX_VAL) begin
                    ovf_ev = 1'b1;
                    next_q = SATURATE ? MAX_VAL : '0;
                end else begin
                    next_q = q + WIDTH'(1);
                end
            end else begin
                if (q == '0) begin
                    udf_ev = 1'b1;
                    next_q = SATURATE ? '0 : MAX_VAL;
                end else begin
                    next_q = q - WIDTH'(1);
                end
            end
        end
    end

    // A set event in the same cycle as clr_flags keeps the flag set.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            q          <= '0;
            wrap       <= 1'b0;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            q          <= next_q;
            wrap       <= (ovf_ev | udf_ev) & ~SATURATE;
            ovf_sticky <= ovf_ev | (ovf_sticky & ~clr_flags);
            udf_sticky <= udf_ev | (udf_sticky & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_updown_counter_p.sv
// Bench for updown_counter_p: a wrapping MAX_VAL=9 instance and a saturating MAX_VAL=15
// instance driven by the same stimulus, each compared against an arithmetic reference model.
module tb_updown_counter_p;

    logic       clk = 1'b0;
    logic       areset;
    logic       enable;
    logic       up;
    logic       load;
    logic [3:0] load_val;
    logic       clr_flags;

    logic [3:0] q_a, q_b;
    logic       at_max_a, at_min_a, wrap_a, ovf_a, udf_a;
    logic       at_max_b, at_min_b, wrap_b, ovf_b, udf_b;

    int errors = 0;
    int checks = 0;

    int maxv [2] = '{9, 15};
    bit sat  [2] = '{1'b0, 1'b1};
    int m_q    [2];
    bit m_wrap [2];
    bit m_ovf  [2];
    bit m_udf  [2];

    updown_counter_p #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) dut_a (
        .clk(clk), .areset(areset), .enable(enable), .up(up), .load(load),
        .load_val(load_val), .clr_flags(clr_flags), .q(q_a), .at_max(at_max_a),
        .at_min(at_min_a), .wrap(wrap_a), .ovf_sticky(ovf_a), .udf_sticky(udf_a)
    );

    updown_counter_p #(.WIDTH(4), .SATURATE(1'b1)) dut_b (
        .clk(clk), .areset(areset), .enable(enable), .up(up), .load(load),
        .load_val(load_val), .clr_flags(clr_flags), .q(q_b), .at_max(at_max_b),
        .at_min(at_min_b), .wrap(wrap_b), .ovf_sticky(ovf_b), .udf_sticky(udf_b)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 0; m_wrap[i] = 1'b0; m_ovf[i] = 1'b0; m_udf[i] = 1'b0;
        end
    endtask

    // Counting modulo MAX_VAL+1, with a clamp on the bound when saturating.
    task automatic modelStep(input bit ld, input int lv, input bit en, input bit u, input bit clr);
        for (int i = 0; i < 2; i++) begin
            bit ovf = 1'b0;
            bit udf = 1'b0;
            int m = maxv[i] + 1;
            if (ld) begin
                m_q[i] = (lv > maxv[i]) ? maxv[i] : lv;
            end else if (en) begin
                if (u) begin
                    ovf = (m_q[i] == maxv[i]);
                    m_q[i] = (ovf && sat[i]) ? maxv[i] : (m_q[i] + 1) % m;
                end else begin
                    udf = (m_q[i] == 0);
                    m_q[i] = (udf && sat[i]) ? 0 : (m_q[i] + m - 1) % m;
                end
            end
            m_wrap[i] = !sat[i] && (ovf || udf);
            m_ovf[i]  = ovf || (m_ovf[i] && !clr);
            m_udf[i]  = udf || (m_udf[i] && !clr);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".q_a"},      32'(q_a),      32'(m_q[0]));
        checkOutput({tag, ".at_max_a"}, 32'(at_max_a), 32'(m_q[0] == maxv[0]));
        checkOutput({tag, ".at_min_a"}, 32'(at_min_a), 32'(m_q[0] == 0));
        checkOutput({tag, ".wrap_a"},   32'(wrap_a),   32'(m_wrap[0]));
        checkOutput({tag, ".ovf_a"},    32'(ovf_a),    32'(m_ovf[0]));
        checkOutput({tag, ".udf_a"},    32'(udf_a),    32'(m_udf[0]));
        checkOutput({tag, ".q_b"},      32'(q_b),      32'(m_q[1]));
        checkOutput({tag, ".at_max_b"}, 32'(at_max_b), 32'(m_q[1] == maxv[1]));
        checkOutput({tag, ".at_min_b"}, 32'(at_min_b), 32'(m_q[1] == 0));
        checkOutput({tag, ".wrap_b"},   32'(wrap_b),   32'(m_wrap[1]));
        checkOutput({tag, ".ovf_b"},    32'(ovf_b),    32'(m_ovf[1]));
        checkOutput({tag, ".udf_b"},    32'(udf_b),    32'(m_udf[1]));
    endtask

    // Inputs change 1 time unit after an edge and are compared 1 unit after the next edge.
    task automatic applyStimulus(input bit ld, input int lv, input bit en, input bit u,
                                 input bit clr, input string tag);
        load      = ld;
        load_val  = 4'(lv);
        enable    = en;
        up        = u;
        clr_flags = clr;
        @(posedge clk);
        modelStep(ld, lv, en, u, clr);
        #1;
        checkAll(tag);
    endtask

    initial begin
        bit en_r;
        bit up_r;

        areset = 1'b1; enable = 1'b0; up = 1'b0; load = 1'b0; load_val = '0; clr_flags = 1'b0;
        modelReset();
        #2;
        checkAll("reset");
        checkOutput("reset_at_min", 32'(at_min_a), 32'd1);
        #2 areset = 1'b0;

        // Wrapping count through the terminal value.
        for (int i = 0; i < 11; i++) applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0, "up11");
        checkOutput("up11_q_a", 32'(q_a), 32'd1);
        checkOutput("up11_ovf_a", 32'(ovf_a), 32'd1);
        checkOutput("up11_q_b", 32'(q_b), 32'd11);

        // Underflow from zero, then clear the sticky flags.
        applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0, "load0");
        applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, "down0");
        checkOutput("down0_q_a", 32'(q_a), 32'd9);
        checkOutput("down0_wrap_a", 32'(wrap_a), 32'd1);
        checkOutput("down0_udf_a", 32'(udf_a), 32'd1);
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, "clr");
        checkOutput("clr_ovf_a", 32'(ovf_a), 32'd0);
        checkOutput("clr_udf_a", 32'(udf_a), 32'd0);

        // Saturation at both bounds on the second instance.
        for (int i = 0; i < 17; i++) applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0, "sat_up");
        checkOutput("sat_up_q_b", 32'(q_b), 32'd15);
        checkOutput("sat_up_at_max_b", 32'(at_max_b), 32'd1);
        checkOutput("sat_up_ovf_b", 32'(ovf_b), 32'd1);
        for (int i = 0; i < 17; i++) applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, "sat_dn");
        checkOutput("sat_dn_q_b", 32'(q_b), 32'd0);
        checkOutput("sat_dn_udf_b", 32'(udf_b), 32'd1);

        // Loads: clamp above the terminal count, no flag side effects.
        applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1, "clr2");
        applyStimulus(1'b1, 12, 1'b1, 1'b1, 1'b0, "load12");
        checkOutput("load12_q_a", 32'(q_a), 32'd9);
        checkOutput("load12_q_b", 32'(q_b), 32'd12);
        checkOutput("load12_ovf_a", 32'(ovf_a), 32'd0);
        applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b0, "load3");
        checkOutput("load3_q_a", 32'(q_a), 32'd3);

        // Set wins over clear in the same cycle.
        applyStimulus(1'b1, 9, 1'b0, 1'b0, 1'b0, "load9");
        applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b1, "setwins");
        checkOutput("setwins_ovf_a", 32'(ovf_a), 32'd1);

        // Random loads/clears with enable toggling every cycle and up every three.
        en_r = 1'b1;
        up_r = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i % 3 == 0) up_r = ~up_r;
            applyStimulus(($urandom % 8) == 0, int'($urandom_range(0, 15)), en_r, up_r,
                          ($urandom % 8) == 0, "rand");
            en_r = ~en_r;
        end

        // Asynchronous reset between edges while counting.
        applyStimulus(1'b1, 6, 1'b0, 1'b0, 1'b0, "load6");
        applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0, "to7");
        checkOutput("to7_q_a", 32'(q_a), 32'd7);
        #3 areset = 1'b1;
        #1;
        modelReset();
        checkAll("async_rst");
        checkOutput("async_rst_q_a", 32'(q_a), 32'd0);
        #2 areset = 1'b0;
        applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0, "resume1");
        checkOutput("resume1_q_a", 32'(q_a), 32'd1);
        applyStimulus(1'b0, 0, 1'b1, 1'b1, 1'b0, "resume2");
        checkOutput("resume2_q_a", 32'(q_a), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
